phase_done_gen: RTL and testbench
=================================

Name: phase_done_gen

Overview:
- Upstream companion to the three-phase Moore completion sequencer (start / done_a / done_b / done_c -> Done).
- Generates the ordered done_a, done_b, done_c completion pulses that sequencer consumes.
- After a start request, runs three back-to-back phases A, B, C of programmable cycle length and emits a one-cycle registered pulse at the end of each phase.
- Lets the sequencer be driven by real timed work instead of bench-forced pulses.

Parameters:
- CNT_W, 8, width of phase length inputs and internal down-counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  run request, sampled only in IDLE.
- abort  input  1  synchronous cancel of a run in progress.
- len_a  input  CNT_W  phase A length in cycles, latched on accepted start.
- len_b  input  CNT_W  phase B length in cycles, latched on accepted start.
- len_c  input  CNT_W  phase C length in cycles, latched on accepted start.
- done_a  output  1  one-cycle pulse, phase A complete.
- done_b  output  1  one-cycle pulse, phase B complete.
- done_c  output  1  one-cycle pulse, phase C complete.
- busy  output  1  high while state is not IDLE.
- phase  output  2  current state code: 0 IDLE, 1 RUN_A, 2 RUN_B, 3 RUN_C.

Behaviour:
- Reset (async, active-high):
  - State IDLE; counter and latched lengths cleared.
  - done_a, done_b, done_c, busy all 0; phase 0.
- Lengths: len_a, len_b, len_c are latched at the accepted start edge. Later changes to the inputs are ignored until the next run. A length of 0 is treated as 1.
- IDLE:
  - start=1 and abort=0 at edge T0 -> state RUN_A, counter loaded with len_a.
  - start=1 and abort=1 at the same edge -> remain IDLE.
- RUN_x: the counter decrements each edge.
  - The edge on which counter==1 is the phase's last edge: the matching done_x register goes high for exactly one cycle, and the counter reloads with the next phase length.
  - RUN_A -> RUN_B -> RUN_C -> IDLE.
- Timing:
  - done_a rises at edge T0+La.
  - done_b rises at T0+La+Lb.
  - done_c rises at T0+La+Lb+Lc, where Lx = max(len_x,1).
  - busy falls and phase returns to 0 at the same edge done_c rises.
- Back-to-back runs: start while busy is ignored and not queued. A start in the cycle where done_c is high is accepted, since the state is already IDLE.
- Abort in RUN_x:
  - Next edge: state IDLE, busy 0, no further done pulses.
  - A done pulse already high in the current cycle still completes its single cycle.
  - If abort coincides with a phase-completion edge, abort wins and no done_x is issued for that edge.
- Reset mid-run clears all outputs immediately, including any done pulse currently high.
- Never more than one done_* high in any cycle. The pulse order is always A, B, C.
- Consecutive pulses are legal when a length is 1 (e.g. done_a then done_b in adjacent cycles).

Optional Feature:
- Macro PHASE_HOLD_EN.
- Defined:
  - Adds input port hold (1 bit, after abort).
  - hold=1 in RUN_x freezes the counter and state; no done pulse is issued while held.
  - Abort and reset override hold.
  - hold has no effect in IDLE.
- Undefined: no hold port; the counter always runs.

Test Plan:
- Reset then start at edge T0 with len_a=5, len_b=5, len_c=5 -> done_a at T0+5, done_b at T0+10, done_c at T0+15, each high 1 cycle; busy high T0..T0+14; phase 1,2,3,0.
- len_a=0, len_b=1, len_c=2, start at T0 -> done_a T0+1, done_b T0+2, done_c T0+4; lengths changed to 9 after T0 have no effect.
- Start at T0 (lengths 4,4,4), abort at edge T0+6 -> done_a at T0+4 only; IDLE and busy 0 from T0+6; no done_b/done_c.
- Start pulsed again at T0+2 while busy -> ignored, done_c still at T0+12. New start in the done_c cycle -> second run's done_a at that edge+len_a.
- Async reset asserted mid RUN_B between edges -> outputs 0 immediately, phase 0; start after release runs normally.
- With PHASE_HOLD_EN: lengths 3,3,3; hold high for 4 cycles during RUN_B -> done_b and done_c each delayed by 4 cycles; abort during hold -> IDLE next edge.

Source files
------------

// File: rtl/phase_done_gen.sv
// phase_done_gen: timed completion-pulse generator for the three-phase
// sequencer. After an accepted start it runs phases A, B and C back to back.
// Each phase lasts a latched, programmable number of cycles. A one-cycle
// registered done_a/done_b/done_c pulse is issued on the last edge of the
// matching phase.
//
// Optional build macro: PHASE_HOLD_EN adds a 'hold' input. While hold is
// high, the counter and state are frozen during a run. With the macro
// undefined, the counter always runs.
module phase_done_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
`ifdef PHASE_HOLD_EN
  input  logic             hold,
`endif
  input  logic [CNT_W-1:0] len_a,
  input  logic [CNT_W-1:0] len_b,
  input  logic [CNT_W-1:0] len_c,
  output logic             done_a,
  output logic             done_b,
  output logic             done_c,
  output logic             busy,
  output logic [1:0]       phase
);

  // State codes double as the externally visible phase number.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2,
    RUN_C = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_b_q, len_b_d;
  logic [CNT_W-1:0] len_c_q, len_c_d;
  logic             done_a_q, done_a_d;
  logic             done_b_q, done_b_d;
  logic             done_c_q, done_c_d;
  logic             hold_act;

`ifdef PHASE_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  // A programmed length of zero runs as a one-cycle phase.
  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
    return (len == '0) ? CNT_W'(1) : len;
  endfunction

  // Next-state logic: accept start, count down, and advance through the phases.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_b_d  = len_b_q;
    len_c_d  = len_c_q;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    done_c_d = 1'b0;

    if (state_q == IDLE) begin
      // Abort in the same cycle as start vetoes the run.
      if (start && !abort) begin
        state_d = RUN_A;
        cnt_d   = eff_len(len_a);
        len_b_d = eff_len(len_b);
        len_c_d = eff_len(len_c);
      end
    end else if (abort) begin
      // Abort beats a coinciding phase completion, so no pulse is issued.
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!hold_act) begin
      if (cnt_q <= CNT_W'(1)) begin
        // This is the phase's last edge: pulse done and load the next phase.
        unique case (state_q)
          RUN_A: begin
            state_d  = RUN_B;
            cnt_d    = len_b_q;
            done_a_d = 1'b1;
          end
          RUN_B: begin
            state_d  = RUN_C;
            cnt_d    = len_c_q;
            done_b_d = 1'b1;
          end
          default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            done_c_d = 1'b1;
          end
        endcase
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // State, counter, latched lengths and done pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_b_q  <= '0;
      len_c_q  <= '0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      done_c_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together
      // from values sampled before the edge, so there are no ordering races.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_b_q  <= len_b_d;
      len_c_q  <= len_c_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      done_c_q <= done_c_d;
    end
  end

  assign done_a = done_a_q;
  assign done_b = done_b_q;
  assign done_c = done_c_q;
  assign busy   = (state_q != IDLE);
  assign phase  = state_q;

endmodule

// File: tb/tb_phase_done_gen.sv
// Directed testbench for phase_done_gen. Every check compares the observed
// vector {done_a, done_b, done_c, busy, phase} with hand-derived values.
// Observations are taken 1 time unit after each rising edge. Index k counts
// edges since the accepted start edge T0.
module tb_phase_done_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
`ifdef PHASE_HOLD_EN
  logic       hold;
`endif
  logic [7:0] len_a, len_b, len_c;
  logic       done_a, done_b, done_c, busy;
  logic [1:0] phase;
  logic [5:0] obs;

  int tests_run    = 0;
  int tests_failed = 0;

  phase_done_gen #(.CNT_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
`ifdef PHASE_HOLD_EN
    .hold   (hold),
`endif
    .len_a  (len_a),
    .len_b  (len_b),
    .len_c  (len_c),
    .done_a (done_a),
    .done_b (done_b),
    .done_c (done_c),
    .busy   (busy),
    .phase  (phase)
  );

  assign obs = {done_a, done_b, done_c, busy, phase};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    exp = 6'b0;
    #3;
    tests_run++;
    if (obs !== exp)
      $display("FAIL reset_asserted got %b exp %b", obs, exp);
    if (obs !== exp) tests_failed++;
    tick();
    tick();
    #2 reset = 1'b0;
    tick();
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL reset_released got %b exp %b", obs, exp);
    end
  endtask

  // Lengths 5,5,5: done_a at 5, done_b at 10, done_c at 15.
  task automatic test_basic();
    logic [5:0] exp;
    logic [1:0] ph;
    len_a = 8'd5; len_b = 8'd5; len_c = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) tick();
      ph  = (k < 5) ? 2'd1 : (k < 10) ? 2'd2 : (k < 15) ? 2'd3 : 2'd0;
      exp = {k == 5, k == 10, k == 15, k < 15, ph};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL basic k=%0d got %b exp %b", k, obs, exp);
      end
    end
  endtask

  // Lengths 0,1,2 act as 1,1,2. Later changes of the inputs are ignored.
  task automatic test_len_zero();
    logic [5:0] exp;
    logic [1:0] ph;
    len_a = 8'd0; len_b = 8'd1; len_c = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    len_a = 8'd9; len_b = 8'd9; len_c = 8'd9;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      ph  = (k < 1) ? 2'd1 : (k < 2) ? 2'd2 : (k < 4) ? 2'd3 : 2'd0;
      exp = {k == 1, k == 2, k == 4, k < 4, ph};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL len_zero k=%0d got %b exp %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_abort();
    logic [5:0] exp;
    logic [1:0] ph;
    // Case 1: lengths 4,4,4 with abort at edge 6 (inside RUN_B).
    len_a = 8'd4; len_b = 8'd4; len_c = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) begin
        abort = (k == 6);
        tick();
        abort = 1'b0;
      end
      ph  = (k < 4) ? 2'd1 : (k < 6) ? 2'd2 : 2'd0;
      exp = {k == 4, 1'b0, 1'b0, k < 6, ph};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL abort_mid k=%0d got %b exp %b", k, obs, exp);
      end
    end
    // Case 2: abort on the edge where phase A would complete, so done_a is never issued.
    len_a = 8'd2; len_b = 8'd2; len_c = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        abort = (k == 2);
        tick();
        abort = 1'b0;
      end
      ph  = (k < 2) ? 2'd1 : 2'd0;
      exp = {1'b0, 1'b0, 1'b0, k < 2, ph};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL abort_on_done k=%0d got %b exp %b", k, obs, exp);
      end
    end
    // Case 3: start and abort on the same edge while IDLE, so the block stays IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k <= 1; k++) begin
      if (k > 0) tick();
      exp = 6'b0;
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL start_with_abort k=%0d got %b exp %b", k, obs, exp);
      end
    end
  endtask

  // Lengths 4,4,4. A start at edge 2 is ignored, and a start at edge 13 (the
  // done_c cycle) is accepted with lengths 3,1,1.
  task automatic test_back_to_back();
    logic [5:0] exp;
    logic [1:0] ph;
    len_a = 8'd4; len_b = 8'd4; len_c = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    len_a = 8'd3; len_b = 8'd1; len_c = 8'd1;
    for (int k = 0; k <= 19; k++) begin
      if (k > 0) begin
        start = (k == 2) || (k == 13);
        tick();
        start = 1'b0;
      end
      ph  = (k < 4)  ? 2'd1 : (k < 8)  ? 2'd2 : (k < 12) ? 2'd3 :
            (k == 12) ? 2'd0 : (k < 16) ? 2'd1 : (k < 17) ? 2'd2 :
            (k < 18) ? 2'd3 : 2'd0;
      exp = {(k == 4) || (k == 16), (k == 8) || (k == 17),
             (k == 12) || (k == 18), (k < 12) || (k >= 13 && k < 18), ph};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL back_to_back k=%0d got %b exp %b", k, obs, exp);
      end
    end
  endtask

  // Asynchronous reset between edges while in RUN_B with done_a high.
  task automatic test_async_reset();
    logic [5:0] exp;
    logic [1:0] ph;
    len_a = 8'd3; len_b = 8'd3; len_c = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL pre_reset got %b exp %b", obs, exp);
    end
    #2 reset = 1'b1;
    #1;
    exp = 6'b0;
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL async_reset got %b exp %b", obs, exp);
    end
    #2 reset = 1'b0;
    tick();
    len_a = 8'd1; len_b = 8'd1; len_c = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick();
      ph  = (k < 1) ? 2'd1 : (k < 2) ? 2'd2 : (k < 3) ? 2'd3 : 2'd0;
      exp = {k == 1, k == 2, k == 3, k < 3, ph};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL after_reset k=%0d got %b exp %b", k, obs, exp);
      end
    end
  endtask

`ifdef PHASE_HOLD_EN
  task automatic test_hold();
    logic [5:0] exp;
    logic [1:0] ph;
    // Lengths 3,3,3 with hold during edges 4..7 in RUN_B: each later pulse shifts by 4.
    len_a = 8'd3; len_b = 8'd3; len_c = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) begin
        hold = (k >= 4) && (k <= 7);
        tick();
        hold = 1'b0;
      end
      ph  = (k < 3) ? 2'd1 : (k < 10) ? 2'd2 : (k < 13) ? 2'd3 : 2'd0;
      exp = {k == 3, k == 10, k == 13, k < 13, ph};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL hold k=%0d got %b exp %b", k, obs, exp);
      end
    end
    // Hold across phase A's completion edge, then abort while still held.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) begin
        hold  = (k >= 2) && (k <= 4);
        abort = (k == 4);
        tick();
        hold  = 1'b0;
        abort = 1'b0;
      end
      ph  = (k < 4) ? 2'd1 : 2'd0;
      exp = {1'b0, 1'b0, 1'b0, k < 4, ph};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL hold_abort k=%0d got %b exp %b", k, obs, exp);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
`ifdef PHASE_HOLD_EN
    hold  = 1'b0;
`endif
    len_a = 8'd0; len_b = 8'd0; len_c = 8'd0;
    test_reset();
    test_basic();
    test_len_zero();
    test_abort();
    test_back_to_back();
    test_async_reset();
`ifdef PHASE_HOLD_EN
    test_hold();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
